// File: rtl/sram_pkg.sv
// Shared encodings and bus widths for the SRAM two-master arbiter.
package sram_pkg;
   localparam int ADR_W = 19;
   localparam int DAT_W = 16;
   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      DRAIN = 2'd3
   } state_t;
endpackage

// File: rtl/wb_port_mux.sv
// Steers the owning master's Wishbone controls to the slave and returns ack/stall per master.
// Purely combinational; non-owner always sees stall=1 and ack=0.
module wb_port_mux
   import sram_pkg::*;
(
   input  logic             owner,
   input  logic             own_st,
   input  logic             route,
   input  logic             stb_en,
   input  logic             force_stall,
   input  logic             m0_stb,
   input  logic             m0_we,
   input  logic [SEL_W-1:0] m0_sel,
   input  logic [ADR_W:1]   m0_adr,
   input  logic [DAT_W-1:0] m0_dat,
   input  logic             m1_stb,
   input  logic             m1_we,
   input  logic [SEL_W-1:0] m1_sel,
   input  logic [ADR_W:1]   m1_adr,
   input  logic [DAT_W-1:0] m1_dat,
   input  logic             s_ack,
   input  logic             s_stall,
   output logic             s_stb,
   output logic             s_we,
   output logic [SEL_W-1:0] s_sel,
   output logic [ADR_W:1]   s_adr,
   output logic [DAT_W-1:0] s_dat,
   output logic             m0_ack,
   output logic             m1_ack,
   output logic             m0_stall,
   output logic             m1_stall
);
   logic owner_stall;

   assign s_stb = stb_en & (owner ? m1_stb : m0_stb);
   assign s_we  = owner ? m1_we  : m0_we;
   assign s_sel = owner ? m1_sel : m0_sel;
   assign s_adr = owner ? m1_adr : m0_adr;
   assign s_dat = owner ? m1_dat : m0_dat;

   // Acks follow the owner through DRAIN too, so in-flight reads still complete.
   assign m0_ack = s_ack & route & ~owner;
   assign m1_ack = s_ack & route &  owner;

   assign owner_stall = ~own_st | force_stall | s_stall;
   assign m0_stall    = owner ? 1'b1 : owner_stall;
   assign m1_stall    = owner ? owner_stall : 1'b1;
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter: CPU (m0) and video fetch (m1) onto one SRAM controller.
// Grant one cycle after request; owner stalled at 3 outstanding or after BURST_LIMIT strobes when contended.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int BURST_LIMIT = 4
) (
   input  logic             clk_i,
   input  logic             _reset_i,
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [SEL_W-1:0] m0_sel_i,
   input  logic [ADR_W:1]   m0_adr_i,
   input  logic [DAT_W-1:0] m0_dat_i,
   output logic             m0_ack_o,
   output logic             m0_stall_o,
   output logic [DAT_W-1:0] m0_dat_o,
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [SEL_W-1:0] m1_sel_i,
   input  logic [ADR_W:1]   m1_adr_i,
   input  logic [DAT_W-1:0] m1_dat_i,
   output logic             m1_ack_o,
   output logic             m1_stall_o,
   output logic [DAT_W-1:0] m1_dat_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [SEL_W-1:0] s_sel_o,
   output logic [ADR_W:1]   s_adr_o,
   output logic [DAT_W-1:0] s_dat_o,
   input  logic             s_ack_i,
   input  logic             s_stall_i,
   input  logic [DAT_W-1:0] s_dat_i
);
   localparam int BW = $clog2(BURST_LIMIT + 1);

   state_t          state;
   logic            last;
   logic [1:0]      outst;
   logic [1:0]      outst_nxt;
   logic [BW-1:0]   burst;

   logic owning, owner_cyc, other_cyc, burst_full, burst_hit;
   logic force_stall, stb_en, accept;

   assign owning      = (state == OWN0) || (state == OWN1);
   assign owner_cyc   = last ? m1_cyc_i : m0_cyc_i;
   assign other_cyc   = last ? m0_cyc_i : m1_cyc_i;
   assign burst_full  = (burst == BW'(BURST_LIMIT));
   assign burst_hit   = owning & burst_full & other_cyc;
   assign force_stall = (outst == 2'd3) | burst_hit;
   assign stb_en      = owning & owner_cyc & ~force_stall;
   assign accept      = s_stb_o & ~s_stall_i;

   assign s_cyc_o  = owning ? owner_cyc : (state == DRAIN);
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   always_comb begin
      outst_nxt = outst;
      if (accept && !s_ack_i && outst != 2'd3)
         outst_nxt = outst + 2'd1;
      else if (!accept && s_ack_i && outst != 2'd0)
         outst_nxt = outst - 2'd1;
   end

   always_ff @(posedge clk_i or negedge _reset_i) begin
      if (!_reset_i) begin
         state <= IDLE;
         last  <= 1'b1;
         outst <= 2'd0;
         burst <= '0;
      end else begin
         case (state)
            IDLE: begin
               outst <= 2'd0;
               burst <= '0;
               if (m0_cyc_i && m1_cyc_i) begin
                  state <= last ? OWN0 : OWN1;
                  last  <= ~last;
               end else if (m0_cyc_i) begin
                  state <= OWN0;
                  last  <= 1'b0;
               end else if (m1_cyc_i) begin
                  state <= OWN1;
                  last  <= 1'b1;
               end
            end
            OWN0, OWN1: begin
               // Owner abandoning the cycle forfeits its pending acks.
               if (!owner_cyc) begin
                  state <= IDLE;
                  outst <= 2'd0;
               end else begin
                  outst <= outst_nxt;
                  if (accept && !burst_full)
                     burst <= burst + 1'b1;
                  if (burst_hit)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               outst <= outst_nxt;
               if (outst == 2'd0)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   wb_port_mux u_mux (
      .owner       (last),
      .own_st      (owning),
      .route       (state != IDLE),
      .stb_en      (stb_en),
      .force_stall (force_stall),
      .m0_stb      (m0_stb_i),
      .m0_we       (m0_we_i),
      .m0_sel      (m0_sel_i),
      .m0_adr      (m0_adr_i),
      .m0_dat      (m0_dat_i),
      .m1_stb      (m1_stb_i),
      .m1_we       (m1_we_i),
      .m1_sel      (m1_sel_i),
      .m1_adr      (m1_adr_i),
      .m1_dat      (m1_dat_i),
      .s_ack       (s_ack_i),
      .s_stall     (s_stall_i),
      .s_stb       (s_stb_o),
      .s_we        (s_we_o),
      .s_sel       (s_sel_o),
      .s_adr       (s_adr_o),
      .s_dat       (s_dat_o),
      .m0_ack      (m0_ack_o),
      .m1_ack      (m1_ack_o),
      .m0_stall    (m0_stall_o),
      .m1_stall    (m1_stall_o)
   );
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; ack routing is scoreboarded by a separate monitor.
module tb_sram_arbiter;
   logic        clk_i = 1'b0;
   logic        _reset_i;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [1:0]  m0_sel_i;
   logic [19:1] m0_adr_i;
   logic [15:0] m0_dat_i;
   logic        m0_ack_o, m0_stall_o;
   logic [15:0] m0_dat_o;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [1:0]  m1_sel_i;
   logic [19:1] m1_adr_i;
   logic [15:0] m1_dat_i;
   logic        m1_ack_o, m1_stall_o;
   logic [15:0] m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [1:0]  s_sel_o;
   logic [19:1] s_adr_o;
   logic [15:0] s_dat_o;
   logic        s_ack_i, s_stall_i;
   logic [15:0] s_dat_i;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];  // {master id, read data}

   sram_arbiter #(.BURST_LIMIT(4)) dut (
      .clk_i(clk_i), ._reset_i(_reset_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o),
      .m0_dat_o(m0_dat_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o),
      .m1_dat_o(m1_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      s_ack_i = 1'b0;
   endtask

   task automatic neg();
      @(negedge clk_i);
   endtask

   // who: 0/1 = ack expected at that master, 2 = ack must reach nobody
   task automatic ackx(input logic [15:0] d, input int who);
      s_ack_i = 1'b1;
      s_dat_i = d;
      if (who < 2) exp_q.push_back({who[0], d});
   endtask

   always @(negedge clk_i) begin
      logic [16:0] e;
      if (m0_ack_o || m1_ack_o) begin
         checks++;
         if (m0_ack_o && m1_ack_o) begin
            errors++;
            $display("FAIL ack_both: m0_ack=1 m1_ack=1, expected one");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected: m0_ack=%0d m1_ack=%0d dat=%0h, expected none",
                     m0_ack_o, m1_ack_o, m0_dat_o);
         end else begin
            e = exp_q.pop_front();
            if ({m1_ack_o, m0_dat_o} !== e || m1_dat_o !== e[15:0]) begin
               errors++;
               $display("FAIL ack_route: got master %0d dat %0h/%0h, expected master %0d dat %0h",
                        m1_ack_o, m0_dat_o, m1_dat_o, e[16], e[15:0]);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      _reset_i = 1'b0;
      {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
      m0_sel_i = 2'b11; m1_sel_i = 2'b11;
      m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
      s_ack_i = 1'b0; s_stall_i = 1'b0; s_dat_i = '0;

      repeat (2) @(posedge clk_i);
      neg();
      chk("rst_s_cyc", s_cyc_o, 0);
      chk("rst_s_stb", s_stb_o, 0);
      chk("rst_m0_stall", m0_stall_o, 1);
      chk("rst_m1_stall", m1_stall_o, 1);
      step(); _reset_i = 1'b1;

      // m0 alone: three writes, acks only to m0
      step(); m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 19'h10; m0_dat_i = 16'h1111;
      neg(); chk("t1_idle_cyc", s_cyc_o, 0);
      step();
      neg();
      chk("t1_grant_cyc", s_cyc_o, 1);
      chk("t1_grant_stb", s_stb_o, 1);
      chk("t1_adr0", s_adr_o, 19'h10);
      chk("t1_we", s_we_o, 1);
      chk("t1_m0_stall", m0_stall_o, 0);
      chk("t1_m1_stall", m1_stall_o, 1);
      step(); m0_adr_i = 19'h11; m0_dat_i = 16'h2222; ackx(16'hA000, 0);
      neg(); chk("t1_adr1", s_adr_o, 19'h11); chk("t1_dat1", s_dat_o, 16'h2222);
      step(); m0_adr_i = 19'h12; m0_dat_i = 16'h3333; ackx(16'hA001, 0);
      step(); m0_stb_i = 0; ackx(16'hA002, 0);
      neg(); chk("t1_stb_low", s_stb_o, 0);
      step(); m0_cyc_i = 0; m0_we_i = 0;
      neg(); chk("t1_cyc_drop", s_cyc_o, 0);
      step();

      // round robin: m0 first after reset, then m1
      _reset_i = 1'b0;
      step(); _reset_i = 1'b1;
      step(); m0_cyc_i = 1; m1_cyc_i = 1;
      neg(); chk("t2_idle_m0_stall", m0_stall_o, 1); chk("t2_idle_m1_stall", m1_stall_o, 1);
      step();
      neg(); chk("t2_first_m0", m0_stall_o, 0); chk("t2_first_m1", m1_stall_o, 1);
      step(); m0_cyc_i = 0; m1_cyc_i = 0;
      step();
      step(); m0_cyc_i = 1; m1_cyc_i = 1;
      step();
      neg();
      chk("t2_second_m1", m1_stall_o, 0);
      chk("t2_second_m0", m0_stall_o, 1);
      chk("t2_second_cyc", s_cyc_o, 1);
      step(); m0_cyc_i = 0; m1_cyc_i = 0;
      step();

      // m1 streams reads while m0 waits: 4 accepts, drain, then m0
      step(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 19'h100;
      step(); m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 19'h200; m0_dat_i = 16'hBEEF;
      neg(); chk("t3_m1_own", m1_stall_o, 0); chk("t3_adr", s_adr_o, 19'h100);
      step(); m1_adr_i = 19'h101; ackx(16'hB000, 1);
      step(); m1_adr_i = 19'h102; ackx(16'hB001, 1);
      step(); m1_adr_i = 19'h103; ackx(16'hB002, 1);
      step(); m1_adr_i = 19'h104;
      neg();
      chk("t3_burst_stall", m1_stall_o, 1);
      chk("t3_burst_stb", s_stb_o, 0);
      chk("t3_burst_cyc", s_cyc_o, 1);
      chk("t3_m0_wait", m0_stall_o, 1);
      step(); ackx(16'hB003, 1);
      neg(); chk("t3_drain_cyc", s_cyc_o, 1); chk("t3_drain_stb", s_stb_o, 0);
      step();
      neg(); chk("t3_drain_last_cyc", s_cyc_o, 1);
      step();
      neg(); chk("t3_idle_gap", s_cyc_o, 0);
      step();
      neg();
      chk("t3_m0_own", m0_stall_o, 0);
      chk("t3_m1_blocked", m1_stall_o, 1);
      chk("t3_m0_adr", s_adr_o, 19'h200);

      // m0 abandons with one outstanding; stray ack goes nowhere
      step(); m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      neg(); chk("t4_cyc_drop", s_cyc_o, 0);
      step(); ackx(16'hF00D, 2);
      neg();
      chk("t4_stray_m0", m0_ack_o, 0);
      chk("t4_stray_m1", m1_ack_o, 0);
      chk("t4_idle_cyc", s_cyc_o, 0);

      // slave stall for 3 cycles, then outstanding limit
      step(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 19'h300; s_stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         neg(); chk("t5_stall_follow", m0_stall_o, 1); chk("t5_stb_shown", s_stb_o, 1);
      end
      step(); s_stall_i = 0;
      neg(); chk("t5_no_phantom", m0_stall_o, 0);
      step(); m0_adr_i = 19'h301;
      step(); m0_adr_i = 19'h302;
      step(); m0_adr_i = 19'h303; ackx(16'hC000, 0);
      neg(); chk("t5_outst3_stall", m0_stall_o, 1); chk("t5_outst3_stb", s_stb_o, 0);
      step();
      neg(); chk("t5_outst2_free", m0_stall_o, 0);

      // reset mid-burst with an ack in flight
      #1; _reset_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 16'hDEAD;
      #1;
      chk("t6_rst_cyc", s_cyc_o, 0);
      chk("t6_rst_stb", s_stb_o, 0);
      chk("t6_rst_m0_stall", m0_stall_o, 1);
      chk("t6_rst_m1_stall", m1_stall_o, 1);
      chk("t6_rst_ack", m0_ack_o, 0);
      step(); _reset_i = 1'b1; m0_adr_i = 19'h400;
      neg(); chk("t6_rel_idle", s_cyc_o, 0);
      step();
      neg(); chk("t6_acc0", m0_stall_o, 0);
      step(); m0_adr_i = 19'h401;
      neg(); chk("t6_acc1", m0_stall_o, 0);
      step(); m0_adr_i = 19'h402;
      neg(); chk("t6_acc2", m0_stall_o, 0);
      step(); m0_adr_i = 19'h403; ackx(16'hC100, 0);
      neg(); chk("t6_limit", m0_stall_o, 1);
      step(); ackx(16'hC101, 0);
      neg(); chk("t6_resume", m0_stall_o, 0);
      step(); m0_adr_i = 19'h404; ackx(16'hC102, 0);
      neg(); chk("t6_lone_unlimited", m0_stall_o, 0);
      step(); m0_stb_i = 0; ackx(16'hC103, 0);
      step(); ackx(16'hC104, 0);
      step(); m0_cyc_i = 0; m0_we_i = 0;
      step();
      step();
      chk("sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
